dpram_mixed_width: RTL and testbench

- Parametrised true dual-port RAM with one clock and ports of different widths.
- Port A is narrow; port B is RATIO times wider and addresses RATIO consecutive A words as one B word.
- Adds byte enables, a selectable read-during-write mode, an optional output register, cross-port collision flagging, and a post-reset clear sweep.
- It sits between the narrow CPU/DMA-side buses and wide SDRAM/video-side fetch paths in the SNES core.

---
 rtl/dpram_mixed_width.sv | 143 ++++++++++++++
 tb/tb_dpram_mixed_width.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_mixed_width.sv
// Single-clock true dual-port RAM: narrow port A, port B is RATIO A-words wide.
// Byte enables, selectable read-during-write, optional output stage, collision flag, reset clear sweep.
module dpram_mixed_width #(
  parameter int A_DATA_W       = 16,
  parameter int A_ADDR_W       = 8,
  parameter int RATIO_LOG2     = 1,
  parameter int OUT_REG        = 0,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [A_DATA_W-1:0] CLEAR_VALUE = '0,
  localparam int B_DATA_W      = A_DATA_W << RATIO_LOG2,
  localparam int B_ADDR_W      = A_ADDR_W - RATIO_LOG2
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    ready,
  input  logic [A_ADDR_W-1:0]     address_a,
  input  logic [A_DATA_W-1:0]     data_a,
  input  logic [A_DATA_W/8-1:0]   be_a,
  input  logic                    wren_a,
  output logic [A_DATA_W-1:0]     q_a,
  input  logic [B_ADDR_W-1:0]     address_b,
  input  logic [B_DATA_W-1:0]     data_b,
  input  logic [B_DATA_W/8-1:0]   be_b,
  input  logic                    wren_b,
  output logic [B_DATA_W-1:0]     q_b,
  output logic                    collision
);

  localparam int RATIO   = 1 << RATIO_LOG2;
  localparam int A_BYTES = A_DATA_W / 8;
  localparam int B_BYTES = B_DATA_W / 8;
  localparam int DEPTH   = 1 << A_ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [A_DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]          state_q, state_d;
  logic [A_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                ready_q;
  logic                coll_q, coll_d;
  logic [A_DATA_W-1:0] qa1_q, qa1_d, qa2_q;
  logic [B_DATA_W-1:0] qb1_q, qb1_d, qb2_q;

  logic                run, wa, wb, a_in_b;
  logic [B_ADDR_W-1:0] a_word_b;
  logic [A_DATA_W-1:0] rd_a, new_a;
  logic [B_DATA_W-1:0] rd_b, new_b;
  logic [A_ADDR_W-1:0] lane_addr [RATIO];
  logic [A_DATA_W-1:0] lane_word [RATIO];
  logic [RATIO-1:0]    lane_we;

  assign run      = (state_q == ST_RUN) && !reset;
  assign wa       = run && wren_a;
  assign wb       = run && wren_b;
  assign a_word_b = address_a[A_ADDR_W-1:RATIO_LOG2];
  assign a_in_b   = (a_word_b == address_b);

  // Lane k of port B is A-word {address_b, RATIO-1-k}: lowest A address in the MSB lane.
  always_comb begin
    rd_a      = mem_q[address_a];
    new_a     = rd_a;
    rd_b      = '0;
    lane_addr = '{default: '0};
    lane_word = '{default: '0};
    lane_we   = '0;
    for (int i = 0; i < A_BYTES; i++) begin
      if (be_a[i]) new_a[8*i +: 8] = data_a[8*i +: 8];
    end
    for (int k = 0; k < RATIO; k++) begin
      lane_addr[k] = A_ADDR_W'((int'(address_b) << RATIO_LOG2) + (RATIO - 1 - k));
      rd_b[k*A_DATA_W +: A_DATA_W] = mem_q[lane_addr[k]];
    end
    new_b = rd_b;
    for (int j = 0; j < B_BYTES; j++) begin
      if (be_b[j]) new_b[8*j +: 8] = data_b[8*j +: 8];
    end
    // A shared word is merged here so port A's enabled bytes override port B's.
    for (int k = 0; k < RATIO; k++) begin
      lane_word[k] = wb ? new_b[k*A_DATA_W +: A_DATA_W] : rd_b[k*A_DATA_W +: A_DATA_W];
      if (wa && (address_a == lane_addr[k])) begin
        for (int i = 0; i < A_BYTES; i++) begin
          if (be_a[i]) lane_word[k][8*i +: 8] = data_a[8*i +: 8];
        end
      end
      lane_we[k] = wb || (wa && (address_a == lane_addr[k]));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (state_q == ST_CLEAR)) mem_q[clr_cnt_q] <= CLEAR_VALUE;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_we[k]) mem_q[lane_addr[k]] <= lane_word[k];
    end
    if (wa && !a_in_b) mem_q[address_a] <= new_a;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + A_ADDR_W'(1);
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
    coll_d = wa && wb && a_in_b;
    qa1_d  = '0;
    qb1_d  = '0;
    if (run) begin
      qa1_d = wren_a ? ((RDW_NEW != 0) ? new_a : qa1_q) : rd_a;
      qb1_d = wren_b ? ((RDW_NEW != 0) ? new_b : qb1_q) : rd_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      coll_q    <= 1'b0;
      qa1_q     <= '0;
      qb1_q     <= '0;
      qa2_q     <= '0;
      qb2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == ST_RUN);
      coll_q    <= coll_d;
      qa1_q     <= qa1_d;
      qb1_q     <= qb1_d;
      qa2_q     <= qa1_q;
      qb2_q     <= qb1_q;
    end
  end

  assign q_a       = (OUT_REG != 0) ? qa2_q : qa1_q;
  assign q_b       = (OUT_REG != 0) ? qb2_q : qb1_q;
  assign ready     = ready_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_dpram_mixed_width.sv
// Directed bench for dpram_mixed_width: five parameter variants share one stimulus stream.
module tb_dpram_mixed_width;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  address_a = '0;
  logic [15:0] data_a = '0;
  logic [1:0]  be_a = '0;
  logic        wren_a = 1'b0;
  logic [6:0]  address_b = '0;
  logic [31:0] data_b = '0;
  logic [3:0]  be_b = '0;
  logic        wren_b = 1'b0;

  // _d default, _n RDW_NEW, _r OUT_REG, _rn OUT_REG+RDW_NEW, _c no clear sweep
  logic        ready_d, ready_n, ready_r, ready_rn, ready_c;
  logic [15:0] q_a_d, q_a_n, q_a_r, q_a_rn, q_a_c;
  logic [31:0] q_b_d, q_b_n, q_b_r, q_b_rn, q_b_c;
  logic        coll_d, coll_n, coll_r, coll_rn, coll_c;

  int n_assert = 0;
  int n_fail   = 0;
  int bad_rdy, bad_q, bad_coll, err_a, err_b;

  always #5 clock = ~clock;

  dpram_mixed_width u_d (.clock(clock), .reset(reset), .ready(ready_d),
    .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .q_a(q_a_d),
    .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .q_b(q_b_d),
    .collision(coll_d));
  dpram_mixed_width #(.RDW_NEW(1)) u_n (.clock(clock), .reset(reset), .ready(ready_n),
    .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .q_a(q_a_n),
    .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .q_b(q_b_n),
    .collision(coll_n));
  dpram_mixed_width #(.OUT_REG(1)) u_r (.clock(clock), .reset(reset), .ready(ready_r),
    .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .q_a(q_a_r),
    .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .q_b(q_b_r),
    .collision(coll_r));
  dpram_mixed_width #(.OUT_REG(1), .RDW_NEW(1)) u_rn (.clock(clock), .reset(reset), .ready(ready_rn),
    .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .q_a(q_a_rn),
    .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .q_b(q_b_rn),
    .collision(coll_rn));
  dpram_mixed_width #(.CLEAR_ON_RESET(0)) u_c (.clock(clock), .reset(reset), .ready(ready_c),
    .address_a(address_a), .data_a(data_a), .be_a(be_a), .wren_a(wren_a), .q_a(q_a_c),
    .address_b(address_b), .data_b(data_b), .be_b(be_b), .wren_b(wren_b), .q_b(q_b_c),
    .collision(coll_c));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0;
    wren_b = 1'b0;
  endtask

  task automatic set_a(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
    address_a = addr;
    data_a    = data;
    be_a      = be;
    wren_a    = 1'b1;
  endtask

  task automatic set_b(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] be);
    address_b = addr;
    data_b    = data;
    be_b      = be;
    wren_b    = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and clear sweep; a colliding write pair mid-sweep must be dropped
    reset = 1'b1;
    idle();
    tick();
    chk("rst_ready", 32'(ready_d), 32'h0);
    chk("rst_q_a", 32'(q_a_d), 32'h0);
    chk("rst_q_b", q_b_d, 32'h0);
    chk("rst_coll", 32'(coll_d), 32'h0);
    chk("rst_q_a_reg", 32'(q_a_r), 32'h0);
    reset     = 1'b0;
    address_a = 8'h10;
    bad_rdy = 0; bad_q = 0; bad_coll = 0;
    for (int i = 1; i <= 255; i++) begin
      if (i == 50) begin
        set_a(8'h03, 16'hBEEF, 2'b11);
        set_b(7'h01, 32'hCAFEF00D, 4'b1111);
      end else begin
        idle();
      end
      tick();
      if (ready_d !== 1'b0) bad_rdy++;
      if (q_a_d !== 16'h0 || q_b_d !== 32'h0) bad_q++;
      if (coll_d !== 1'b0) bad_coll++;
      if (i == 1) chk("noclr_ready_early", 32'(ready_c), 32'h1);
      if (i == 50) chk("noclr_coll", 32'(coll_c), 32'h1);
    end
    chk("sweep_ready_low_cycles", 32'(bad_rdy), 32'h0);
    chk("sweep_q_held_zero", 32'(bad_q), 32'h0);
    chk("sweep_coll_zero", 32'(bad_coll), 32'h0);
    idle();
    tick();
    chk("sweep_ready_rise", 32'(ready_d), 32'h1);

    // Whole array reads back as zero through both ports
    err_a = 0; err_b = 0;
    for (int i = 0; i < 256; i++) begin
      address_a = 8'(i);
      address_b = 7'(i);
      tick();
      if (q_a_d !== 16'h0) err_a++;
      if (q_b_d !== 32'h0) err_b++;
    end
    chk("sweep_a_zero", 32'(err_a), 32'h0);
    chk("sweep_b_zero", 32'(err_b), 32'h0);
    address_a = 8'h03;
    address_b = 7'h01;
    tick();
    chk("sweep_write_lost_a", 32'(q_a_d), 32'h0);
    chk("sweep_write_lost_b", q_b_d, 32'h0);
    chk("noclr_merge_b", q_b_c, 32'hCAFEBEEF);

    // Width mapping and B byte enables
    set_a(8'h10, 16'h1234, 2'b11);
    tick();
    set_a(8'h11, 16'h5678, 2'b11);
    tick();
    idle();
    address_b = 7'h08;
    tick();
    chk("map_q_b", q_b_d, 32'h12345678);
    set_b(7'h08, 32'hAABBCCDD, 4'b0011);
    tick();
    idle();
    address_a = 8'h10;
    tick();
    chk("map_be_b_hi", 32'(q_a_d), 32'h1234);
    address_a = 8'h11;
    tick();
    chk("map_be_b_lo", 32'(q_a_d), 32'hCCDD);

    // Same-port read-during-write in all four q variants
    address_a = 8'h10;
    address_b = 7'h09;
    tick();
    tick();
    chk("rdw_pre_q_a", 32'(q_a_d), 32'h1234);
    set_a(8'h10, 16'hFFFF, 2'b01);
    set_b(7'h09, 32'h5A0000A5, 4'b1001);
    tick();
    chk("rdw_hold_a", 32'(q_a_d), 32'h1234);
    chk("rdw_new_a", 32'(q_a_n), 32'h12FF);
    chk("rdw_reg_new_a_wait", 32'(q_a_rn), 32'h1234);
    chk("rdw_hold_b", q_b_d, 32'h0);
    chk("rdw_new_b", q_b_n, 32'h5A0000A5);
    idle();
    tick();
    chk("rdw_after_a", 32'(q_a_d), 32'h12FF);
    chk("rdw_reg_hold_a", 32'(q_a_r), 32'h1234);
    chk("rdw_reg_new_a", 32'(q_a_rn), 32'h12FF);
    chk("rdw_after_b", q_b_d, 32'h5A0000A5);
    tick();
    chk("rdw_reg_after_a", 32'(q_a_r), 32'h12FF);

    // Collisions: full overlap, disjoint words, partial bytes, no enables
    set_a(8'h20, 16'h1111, 2'b11);
    set_b(7'h10, 32'h22223333, 4'b1111);
    tick();
    chk("coll_full", 32'(coll_d), 32'h1);
    idle();
    address_a = 8'h20;
    tick();
    chk("coll_pulse_end", 32'(coll_d), 32'h0);
    chk("coll_a_wins", 32'(q_a_d), 32'h1111);
    address_a = 8'h21;
    tick();
    chk("coll_b_other", 32'(q_a_d), 32'h3333);
    set_a(8'h30, 16'hABCD, 2'b11);
    set_b(7'h20, 32'h0F0F0F0F, 4'b1111);
    tick();
    chk("coll_none", 32'(coll_d), 32'h0);
    set_a(8'h50, 16'hAAAA, 2'b01);
    set_b(7'h28, 32'hBBBBCCCC, 4'b1111);
    tick();
    chk("coll_partial", 32'(coll_d), 32'h1);
    set_a(8'h60, 16'hFFFF, 2'b00);
    set_b(7'h30, 32'hFFFFFFFF, 4'b0000);
    tick();
    chk("coll_no_enables", 32'(coll_d), 32'h1);
    idle();
    address_a = 8'h50;
    address_b = 7'h30;
    tick();
    chk("coll_byte_merge", 32'(q_a_d), 32'hBBAA);
    chk("coll_no_enables_data", q_b_d, 32'h0);
    address_a = 8'h51;
    tick();
    chk("coll_partial_other", 32'(q_a_d), 32'hCCCC);

    // Cross-port read returns old data; top B word
    address_b = 7'h10;
    set_a(8'h21, 16'h4444, 2'b11);
    tick();
    chk("xrd_b_old", q_b_d, 32'h11113333);
    idle();
    tick();
    chk("xrd_b_new", q_b_d, 32'h11114444);
    address_a = 8'h40;
    set_b(7'h20, 32'h12121212, 4'b1111);
    tick();
    chk("xrd_a_old", 32'(q_a_d), 32'h0F0F);
    idle();
    tick();
    chk("xrd_a_new", 32'(q_a_d), 32'h1212);
    set_b(7'h7F, 32'hDEADBEEF, 4'b1111);
    tick();
    idle();
    address_a = 8'hFF;
    tick();
    chk("top_lo", 32'(q_a_d), 32'hBEEF);
    address_a = 8'hFE;
    tick();
    chk("top_hi", 32'(q_a_d), 32'hDEAD);

    // Reset without sweep keeps contents; reset mid-sweep restarts the sweep
    reset = 1'b1;
    address_a = 8'h03;
    tick();
    chk("rst2_ready_d", 32'(ready_d), 32'h0);
    chk("rst2_ready_c", 32'(ready_c), 32'h0);
    reset = 1'b0;
    tick();
    chk("noclr_ready", 32'(ready_c), 32'h1);
    chk("noclr_keep_a3", 32'(q_a_c), 32'hBEEF);
    chk("clr_ready_low", 32'(ready_d), 32'h0);
    address_a = 8'h02;
    tick();
    chk("noclr_keep_a2", 32'(q_a_c), 32'hCAFE);
    for (int i = 0; i < 98; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad_rdy = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (ready_d !== 1'b0) bad_rdy++;
    end
    chk("restart_ready_low", 32'(bad_rdy), 32'h0);
    tick();
    chk("restart_ready_rise", 32'(ready_d), 32'h1);
    address_a = 8'h20;
    tick();
    chk("restart_cleared", 32'(q_a_d), 32'h0);
    chk("noclr_keep_a20", 32'(q_a_c), 32'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
